// File: rtl/uart_bus_master_pkg.sv
// uart_bus_master_pkg: command/response byte values, bridge FSM encoding
// and a ceiling-log2 helper used to size the baud and timeout counters.
package uart_bus_master_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP,
    ST_ERR
  } state_t;

  // Smallest n with 2**n >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_bus_master_phy.sv
// uart_bus_master_phy: 8x oversampling baud tick, 8N1 receiver with a
// 2-flop synchronizer, and 8N1 transmitter. Byte-level handshake only.
module uart_bus_master_phy
  import uart_bus_master_pkg::*;
#(
  parameter int UART_DIV = 13
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_ferr,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_busy
);

  localparam int DIV_W = (clog2(UART_DIV) < 1) ? 1 : clog2(UART_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UART_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  logic       r_rx_s1, r_rx_s2, r_rx_prev, r_rx_act;
  logic [2:0] r_rx_tcnt;
  logic [3:0] r_rx_bit;
  logic [7:0] r_rx_sh;
  logic       r_rx_strobe, r_rx_ferr;

  logic       r_tx, r_tx_act;
  logic [2:0] r_tx_tcnt;
  logic [3:0] r_tx_left;
  logic [8:0] r_tx_sh;

  assign w_tick    = (r_div == DIV_LAST);
  assign rx_byte   = r_rx_sh;
  assign rx_strobe = r_rx_strobe;
  assign rx_ferr   = r_rx_ferr;
  assign ser_tx    = r_tx;
  assign tx_busy   = r_tx_act;

  // Free-running divider producing one oversample tick every UART_DIV clocks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge start detect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= ser_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Receiver: sample at tick 4 of each bit; bit 0 is start, bit 9 is stop.
  // A start needs a high-to-low edge, so a line held low after a bad stop
  // bit does not immediately retrigger.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_act    <= 1'b0;
      r_rx_tcnt   <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_rx_strobe <= 1'b0;
      r_rx_ferr   <= 1'b0;
    end else begin
      r_rx_strobe <= 1'b0;
      r_rx_ferr   <= 1'b0;
      if (!r_rx_act) begin
        if (r_rx_prev && !r_rx_s2) begin
          r_rx_act  <= 1'b1;
          r_rx_tcnt <= '0;
          r_rx_bit  <= '0;
        end
      end else if (w_tick) begin
        r_rx_tcnt <= r_rx_tcnt + 3'd1;
        if (r_rx_tcnt == 3'd3) begin
          r_rx_bit <= r_rx_bit + 4'd1;
          if (r_rx_bit == 4'd0) begin
            if (r_rx_s2) r_rx_act <= 1'b0;
          end else if (r_rx_bit == 4'd9) begin
            r_rx_act <= 1'b0;
            if (r_rx_s2) r_rx_strobe <= 1'b1;
            else         r_rx_ferr   <= 1'b1;
          end else begin
            r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
          end
        end
      end
    end
  end

  // Transmitter: start bit driven at load, then D0..D7 and stop, 8 ticks each.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx      <= 1'b1;
      r_tx_act  <= 1'b0;
      r_tx_tcnt <= '0;
      r_tx_left <= '0;
      r_tx_sh   <= '0;
    end else if (!r_tx_act) begin
      if (tx_load) begin
        r_tx      <= 1'b0;
        r_tx_sh   <= {1'b1, tx_byte};
        r_tx_left <= 4'd10;
        r_tx_tcnt <= '0;
        r_tx_act  <= 1'b1;
      end
    end else if (w_tick) begin
      r_tx_tcnt <= r_tx_tcnt + 3'd1;
      if (r_tx_tcnt == 3'd7) begin
        r_tx_left <= r_tx_left - 4'd1;
        if (r_tx_left == 4'd1) begin
          r_tx     <= 1'b1;
          r_tx_act <= 1'b0;
        end else begin
          r_tx    <= r_tx_sh[0];
          r_tx_sh <= {1'b1, r_tx_sh[8:1]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART command frames (W addr data / R addr) to native
// memory bus transactions, with ack/read-data/error replies on the same line.
// Optional inter-byte timeout: define UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int UART_CLK       = 12000000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        rx_drop
);

  localparam int UART_DIV = UART_CLK / (BAUD_RATE * 8);
  localparam int DIV_EFF  = (UART_DIV < 1) ? 1 : UART_DIV;

  logic [7:0] w_rx_byte;
  logic       w_rx_strobe, w_rx_ferr, w_tx_busy, w_to_hit;

  state_t      r_state;
  logic        r_wr;
  logic [1:0]  r_cnt;
  logic [31:0] r_resp;
  logic [2:0]  r_left;
  logic [7:0]  r_tx_byte;
  logic        r_tx_load;

  uart_bus_master_phy #(.UART_DIV(DIV_EFF)) u_phy (
    .clk       (clk),
    .resetn    (resetn),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .rx_byte   (w_rx_byte),
    .rx_strobe (w_rx_strobe),
    .rx_ferr   (w_rx_ferr),
    .tx_byte   (r_tx_byte),
    .tx_load   (r_tx_load),
    .tx_busy   (w_tx_busy)
  );

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Silence counter while a command frame is partially received.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_to_cnt <= '0;
    else if ((r_state == ST_ADDR || r_state == ST_DATA) && !w_rx_strobe && !w_to_hit)
      r_to_cnt <= r_to_cnt + TO_W'(1);
    else r_to_cnt <= '0;
  end
`else
  // No timeout hardware: a partial frame waits forever (expression is constant false).
  assign w_to_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Command FSM: frame parsing, bus request, reply sequencing, status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_wr      <= 1'b0;
      r_cnt     <= '0;
      r_resp    <= '0;
      r_left    <= '0;
      r_tx_byte <= '0;
      r_tx_load <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      busy      <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rx_strobe) begin
            busy  <= 1'b1;
            r_cnt <= '0;
            if (w_rx_byte == OP_WRITE || w_rx_byte == OP_READ) begin
              r_wr    <= (w_rx_byte == OP_WRITE);
              rx_drop <= 1'b0;
              r_state <= ST_ADDR;
            end else begin
              r_resp  <= {24'h0, RSP_ERR};
              r_left  <= 3'd1;
              r_state <= ST_ERR;
            end
          end
        end
        ST_ADDR: begin
          if (w_rx_strobe) begin
            mem_addr[8*r_cnt +: 8] <= w_rx_byte;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_wr) begin
                r_state <= ST_DATA;
              end else begin
                mem_wstrb <= 4'h0;
                mem_valid <= 1'b1;
                r_state   <= ST_BUS;
              end
            end
          end else if (w_rx_ferr || w_to_hit) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (w_rx_strobe) begin
            mem_wdata[8*r_cnt +: 8] <= w_rx_byte;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              mem_wstrb <= 4'hF;
              mem_valid <= 1'b1;
              r_state   <= ST_BUS;
            end
          end else if (w_rx_ferr || w_to_hit) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (w_rx_strobe) rx_drop <= 1'b1;
          if (mem_ready) begin
            mem_valid <= 1'b0;
            r_resp    <= r_wr ? {24'h0, RSP_ACK} : mem_rdata;
            r_left    <= r_wr ? 3'd1 : 3'd4;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP, ST_ERR: begin
          if (w_rx_strobe) rx_drop <= 1'b1;
          // r_tx_load blocks a second load before the phy raises tx_busy.
          if (!r_tx_load && !w_tx_busy) begin
            if (r_left != 3'd0) begin
              r_tx_byte <= r_resp[7:0];
              r_resp    <= {8'h0, r_resp[31:8]};
              r_left    <= r_left - 3'd1;
              r_tx_load <= 1'b1;
            end else begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
